// File: rtl/simplez_core.sv
// SIMPLEZ CPU core: 8-instruction accumulator machine with an external synchronous
// memory port and one memory-mapped LED/switch word. All state changes on the falling clock edge.
module simplez_core #(
   parameter int               DATAW   = 12,
   parameter int               ADDRW   = 9,
   parameter logic [ADDRW-1:0] IO_ADDR = 9'o100,
   parameter int               IOW     = 4,
   parameter logic [ADDRW-1:0] RST_PC  = '0
) (
   input  logic             clk,
   input  logic             rst,
   output logic [ADDRW-1:0] mem_addr,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [DATAW-1:0] mem_wdata,
   input  logic [DATAW-1:0] mem_rdata,
   input  logic [IOW-1:0]   sw,
   output logic [IOW-1:0]   leds,
   output logic             instr_done,
   output logic             stop
);

   typedef enum logic [2:0] {S_F0, S_F1, S_X0, S_X1, S_HLT} state_t;

   localparam logic [2:0] OP_ST  = 3'd0;
   localparam logic [2:0] OP_LD  = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_BR  = 3'd3;
   localparam logic [2:0] OP_BZ  = 3'd4;
   localparam logic [2:0] OP_CLR = 3'd5;
   localparam logic [2:0] OP_DEC = 3'd6;

   state_t           state_q, state_d;
   logic [ADDRW-1:0] cp_q, cp_d;
   logic [DATAW-1:0] ac_q, ac_d;
   logic [DATAW-1:0] ri_q, ri_d;
   logic [IOW-1:0]   leds_q, leds_d;

   logic [2:0]       co;
   logic [ADDRW-1:0] cd;
   logic [DATAW-1:0] operand;

   function automatic logic [DATAW-1:0] add_wrap(input logic [DATAW-1:0] a,
                                                  input logic [DATAW-1:0] b);
      return a + b;
   endfunction

   assign co        = ri_q[DATAW-1 -: 3];
   assign cd        = ri_q[ADDRW-1:0];
   // Only execute-phase operand reads see the switches; fetches always go to memory.
   assign operand   = (cd == IO_ADDR) ? DATAW'(sw) : mem_rdata;
   assign mem_wdata = ac_q;
   assign leds      = leds_q;

   always_comb begin
      state_d    = state_q;
      cp_d       = cp_q;
      ac_d       = ac_q;
      ri_d       = ri_q;
      leds_d     = leds_q;
      mem_addr   = '0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      instr_done = 1'b0;
      stop       = 1'b0;
      case (state_q)
         S_F0: begin
            mem_addr = cp_q;
            mem_rd   = 1'b1;
            state_d  = S_F1;
         end
         S_F1: begin
            ri_d    = mem_rdata;
            cp_d    = cp_q + ADDRW'(1);
            state_d = S_X0;
         end
         S_X0: begin
            state_d    = S_F0;
            instr_done = 1'b1;
            case (co)
               OP_ST: begin
                  mem_addr = cd;
                  if (cd == IO_ADDR) leds_d = ac_q[IOW-1:0];
                  else               mem_wr = 1'b1;
               end
               OP_LD, OP_ADD: begin
                  mem_addr   = cd;
                  mem_rd     = 1'b1;
                  instr_done = 1'b0;
                  state_d    = S_X1;
               end
               OP_BR:   cp_d = cd;
               OP_BZ:   if (ac_q == '0) cp_d = cd;
               OP_CLR:  ac_d = '0;
               OP_DEC:  ac_d = add_wrap(ac_q, '1);
               default: state_d = S_HLT;
            endcase
         end
         S_X1: begin
            instr_done = 1'b1;
            state_d    = S_F0;
            if (co == OP_LD) ac_d = operand;
            else             ac_d = add_wrap(ac_q, operand);
         end
         S_HLT:   stop = 1'b1;
         default: state_d = S_F0;
      endcase
      // Reset aborts any strobe in the same cycle, including an ST in flight.
      if (rst) begin
         mem_rd = 1'b0;
         mem_wr = 1'b0;
      end
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         state_q <= S_F0;
         cp_q    <= RST_PC;
         ac_q    <= '0;
         ri_q    <= '0;
         leds_q  <= '0;
      end else begin
         state_q <= state_d;
         cp_q    <= cp_d;
         ac_q    <= ac_d;
         ri_q    <= ri_d;
         leds_q  <= leds_d;
      end
   end

endmodule

// File: tb/tb_simplez_core.sv
// Bench for simplez_core: synchronous memory model plus an instruction-level
// reference interpreter that predicts fetch address, latency, writes, AC and LEDs.
module tb_simplez_core;
   localparam int DATAW = 12;
   localparam int ADDRW = 9;
   localparam int IOW   = 4;
   localparam int IOA   = 64;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [ADDRW-1:0] mem_addr;
   logic             mem_rd, mem_wr, instr_done, stop;
   logic [DATAW-1:0] mem_wdata;
   logic [DATAW-1:0] mem_rdata = '0;
   logic [IOW-1:0]   sw = '0;
   logic [IOW-1:0]   leds;

   logic [DATAW-1:0] mem [512];
   logic [DATAW-1:0] ref_mem [512];
   logic             ld_en = 1'b0, ld_clr = 1'b0;
   logic [ADDRW-1:0] ld_addr = '0;
   logic [DATAW-1:0] ld_data = '0;

   logic [ADDRW-1:0] r_cp;
   logic [DATAW-1:0] r_ac;
   logic [IOW-1:0]   r_leds;
   int               fetch_q[$];
   int               tot_cyc;
   int               errors = 0;
   int               checks = 0;

   simplez_core dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .sw(sw), .leds(leds),
      .instr_done(instr_done), .stop(stop)
   );

   always #5 clk = ~clk;

   // Memory on the rising edge, half a cycle after the core drives address/strobes.
   always @(posedge clk) begin
      if (ld_clr) begin
         for (int i = 0; i < 512; i++) mem[i] <= '0;
      end else if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr];
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input int a, input logic [DATAW-1:0] d);
      ref_mem[a] = d;
      ld_addr = ADDRW'(a);
      ld_data = d;
      ld_en = 1'b1;
      cyc();
      ld_en = 1'b0;
   endtask

   task automatic begin_prog();
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 512; i++) ref_mem[i] = '0;
      ld_clr = 1'b1;
      cyc();
      ld_clr = 1'b0;
      r_cp = '0;
      r_ac = '0;
      r_leds = '0;
   endtask

   task automatic release_rst();
      @(negedge clk);
      #1 rst = 1'b0;
      cyc();
   endtask

   // Executes up to max_instr instructions, starting at an F0 sample point.
   task automatic run_prog(input int max_instr);
      logic [DATAW-1:0] instr, opnd;
      int op, cd, n, exp_lat;
      bit saw_wr, saw_both, exp_wr, halted;
      halted = 0;
      tot_cyc = 0;
      fetch_q.delete();
      for (int k = 0; k < max_instr && !halted; k++) begin
         checks++;
         if (mem_rd !== 1'b1 || mem_addr !== r_cp) begin
            errors++;
            $display("FAIL fetch: rd=%b addr=%0d, expected rd=1 addr=%0d", mem_rd, mem_addr, r_cp);
         end
         fetch_q.push_back(int'(mem_addr));
         instr = ref_mem[r_cp];
         op = int'(instr[11:9]);
         cd = int'(instr[8:0]);
         opnd = (cd == IOA) ? DATAW'(sw) : ref_mem[cd];
         r_cp = r_cp + 1;
         exp_wr = 0;
         exp_lat = 3;
         case (op)
            0: if (cd == IOA) r_leds = r_ac[3:0];
               else begin ref_mem[cd] = r_ac; exp_wr = 1; end
            1: begin r_ac = opnd; exp_lat = 4; end
            2: begin r_ac = r_ac + opnd; exp_lat = 4; end
            3: r_cp = ADDRW'(cd);
            4: if (r_ac == 0) r_cp = ADDRW'(cd);
            5: r_ac = 0;
            6: r_ac = r_ac - 1;
            default: halted = 1;
         endcase
         n = 1;
         saw_wr = 0;
         saw_both = 0;
         while (instr_done !== 1'b1 && n < 8) begin
            cyc();
            n++;
            if (mem_wr === 1'b1) saw_wr = 1;
            if (mem_rd === 1'b1 && mem_wr === 1'b1) saw_both = 1;
         end
         tot_cyc += n;
         checks++;
         if (n != exp_lat) begin
            errors++;
            $display("FAIL latency op=%0d: took %0d clk, expected %0d", op, n, exp_lat);
         end
         checks++;
         if (saw_wr != exp_wr || saw_both) begin
            errors++;
            $display("FAIL write_strobe op=%0d cd=%0d: wr=%b both=%b, expected wr=%b both=0",
                     op, cd, saw_wr, saw_both, exp_wr);
         end
         cyc();
         checks++;
         if (mem_wdata !== r_ac || leds !== r_leds || stop !== halted) begin
            errors++;
            $display("FAIL arch_state op=%0d: ac=%h leds=%h stop=%b, expected ac=%h leds=%h stop=%b",
                     op, mem_wdata, leds, stop, r_ac, r_leds, halted);
         end
         if (exp_wr) begin
            checks++;
            if (mem[cd] !== ref_mem[cd]) begin
               errors++;
               $display("FAIL mem_store[%0d]: got %h expected %h", cd, mem[cd], ref_mem[cd]);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      checks++;
      if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || stop !== 1'b0 || leds !== 4'h0 ||
          mem_wdata !== 12'h000 || instr_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: rd=%b wr=%b stop=%b leds=%h ac=%h done=%b, expected all 0",
                  mem_rd, mem_wr, stop, leds, mem_wdata, instr_done);
      end
   endtask

   task automatic test_ld_st();
      begin_prog();
      poke(10, 12'h5A3);
      poke(0, 12'h20A);
      poke(1, 12'h00B);
      poke(2, 12'hE00);
      release_rst();
      run_prog(10);
      checks++;
      if (mem[11] !== 12'h5A3 || stop !== 1'b1 || mem_wdata !== 12'h5A3 || tot_cyc != 10) begin
         errors++;
         $display("FAIL ld_st: mem11=%h stop=%b ac=%h cycles=%0d, expected 5a3 1 5a3 10",
                  mem[11], stop, mem_wdata, tot_cyc);
      end
   endtask

   task automatic test_add_wrap();
      begin_prog();
      poke(20, 12'hFFF);
      poke(21, 12'h001);
      poke(0, 12'h214);
      poke(1, 12'h415);
      poke(2, 12'h01E);
      poke(3, 12'hA00);
      poke(4, 12'hC00);
      poke(5, 12'h01F);
      poke(6, 12'hE00);
      poke(30, 12'h777);
      release_rst();
      run_prog(10);
      checks++;
      if (mem[30] !== 12'h000 || mem[31] !== 12'hFFF) begin
         errors++;
         $display("FAIL add_wrap: mem30=%h mem31=%h, expected 000 fff", mem[30], mem[31]);
      end
   endtask

   task automatic test_branch();
      begin_prog();
      poke(0, 12'hA00);
      poke(1, 12'h808);
      poke(8, 12'hC00);
      poke(9, 12'h808);
      poke(10, 12'h600);
      release_rst();
      run_prog(6);
      checks++;
      if (fetch_q.size() != 6 || fetch_q[0] != 0 || fetch_q[1] != 1 || fetch_q[2] != 8 ||
          fetch_q[3] != 9 || fetch_q[4] != 10 || fetch_q[5] != 0) begin
         errors++;
         $display("FAIL branch_trace: got %p, expected '{0,1,8,9,10,0}", fetch_q);
      end
   endtask

   task automatic test_io();
      begin_prog();
      sw = 4'h6;
      poke(40, 12'h00D);
      poke(64, 12'hABC);
      poke(0, 12'h228);
      poke(1, 12'h040);
      poke(2, 12'h240);
      poke(3, 12'h029);
      poke(4, 12'hE00);
      release_rst();
      run_prog(10);
      checks++;
      if (leds !== 4'hD || mem[41] !== 12'h006 || mem[64] !== 12'hABC) begin
         errors++;
         $display("FAIL io: leds=%h mem41=%h mem64=%h, expected d 006 abc", leds, mem[41], mem[64]);
      end
   endtask

   task automatic test_reset_mid();
      begin_prog();
      poke(40, 12'h7F5);
      poke(5, 12'h123);
      poke(0, 12'h228);
      poke(1, 12'h040);
      poke(2, 12'h005);
      release_rst();
      run_prog(2);
      cyc();
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (mem_wr !== 1'b0 || mem_rd !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort_strobe: wr=%b rd=%b, expected 0 0", mem_wr, mem_rd);
      end
      cyc();
      checks++;
      if (mem[5] !== 12'h123) begin
         errors++;
         $display("FAIL reset_abort_mem: mem5=%h, expected 123", mem[5]);
      end
      @(negedge clk);
      #1 rst = 1'b0;
      cyc();
      checks++;
      if (mem_addr !== 9'd0 || mem_rd !== 1'b1 || mem_wdata !== 12'h000 || leds !== 4'h0) begin
         errors++;
         $display("FAIL reset_restart: addr=%0d rd=%b ac=%h leds=%h, expected 0 1 000 0",
                  mem_addr, mem_rd, mem_wdata, leds);
      end
   endtask

   task automatic test_halt_hold();
      int bad;
      begin_prog();
      poke(40, 12'h3C7);
      poke(0, 12'h228);
      poke(1, 12'hE00);
      release_rst();
      run_prog(5);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         if (stop !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || instr_done !== 1'b0 ||
             mem_wdata !== 12'h3C7 || mem_addr !== 9'd0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL halt_hold: %0d bad cycles of 100, expected 0 (stop=%b rd=%b wr=%b ac=%h)",
                  bad, stop, mem_rd, mem_wr, mem_wdata);
      end
   endtask

   task automatic test_random();
      int op, cd;
      for (int t = 0; t < 6; t++) begin
         begin_prog();
         sw = IOW'($urandom);
         for (int a = 0; a < 128; a++) begin
            op = $urandom_range(0, 7);
            if (op == 7 && $urandom_range(0, 3) != 0) op = 5;
            cd = ($urandom_range(0, 7) == 0) ? IOA : $urandom_range(0, 127);
            poke(a, DATAW'((op << 9) | cd));
         end
         release_rst();
         run_prog(50);
      end
   endtask

   initial begin
      test_reset();
      test_ld_st();
      test_add_wrap();
      test_branch();
      test_io();
      test_reset_mid();
      test_halt_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
